// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access (M) and write-back (W) pipeline stages of a scalar integer
// pipeline. The M register captures the instruction leaving execute, issues
// at most one data-memory request per instruction, and provides forwarding
// and load-use hazard information. The W register captures M on every edge
// and drives the register-file write port. It selects load data from the
// synchronous, 1-cycle-latency data memory or selects the ALU result.
//
// Ports
//   CLK, RSTN        clock (rising edge) / asynchronous active-low reset
//   STALL            freeze the M register (hazard unit)
//   EX_VALID         execute stage holds a live instruction
//   EX_ALURES        ALU result / effective byte address
//   EX_STDATA        store data
//   EX_MEMOP         00 none, 01 load, 10 store, 11 reserved (acts as none)
//   EX_RD, EX_WEN    destination register / register-write request
//   DREQ, DRW        data-memory request / direction (1 write, 0 read)
//   DADDR, DWDATA    word address / write data
//   DRDATA           read data, valid the cycle after a read request
//   RF_WEN, RF_WA, RF_DI           register-file write port
//   FWD_M_EN, FWD_M_RD, FWD_M_DATA M-stage forwarding source
//   LOAD_IN_M, M_RD                load-use hazard information
// -----------------------------------------------------------------------------
module mem_wb_stage (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        STALL,
  input  logic        EX_VALID,
  input  logic [31:0] EX_ALURES,
  input  logic [31:0] EX_STDATA,
  input  logic [1:0]  EX_MEMOP,
  input  logic [4:0]  EX_RD,
  input  logic        EX_WEN,
  output logic        DREQ,
  output logic        DRW,
  output logic [29:0] DADDR,
  output logic [31:0] DWDATA,
  input  logic [31:0] DRDATA,
  output logic        RF_WEN,
  output logic [4:0]  RF_WA,
  output logic [31:0] RF_DI,
  output logic        FWD_M_EN,
  output logic [4:0]  FWD_M_RD,
  output logic [31:0] FWD_M_DATA,
  output logic        LOAD_IN_M,
  output logic [4:0]  M_RD
);

  typedef enum logic [1:0] {
    MEMOP_NONE  = 2'b00,
    MEMOP_LOAD  = 2'b01,
    MEMOP_STORE = 2'b10,
    MEMOP_RSVD  = 2'b11
  } memop_e;

  // ---------------------------------------------------------------------------
  // M register
  // ---------------------------------------------------------------------------
  logic        m_valid;
  memop_e      m_memop;
  logic [31:0] m_alures;
  logic [31:0] m_stdata;
  logic [4:0]  m_rd;
  logic        m_wen;
  // fresh marks an entry that has not yet been handed to W. A stalled entry
  // loses fresh after its first edge, so it issues memory and reaches W once.
  logic        m_fresh;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_valid  <= 1'b0;
      m_memop  <= MEMOP_NONE;
      m_alures <= '0;
      m_stdata <= '0;
      m_rd     <= '0;
      m_wen    <= 1'b0;
      m_fresh  <= 1'b0;
    end else if (!STALL) begin
      m_valid  <= EX_VALID;
      m_memop  <= memop_e'(EX_MEMOP);
      m_alures <= EX_ALURES;
      m_stdata <= EX_STDATA;
      m_rd     <= EX_RD;
      m_wen    <= EX_WEN;
      m_fresh  <= 1'b1;
    end else begin
      m_fresh  <= 1'b0;
    end
  end

  logic m_is_load;
  logic m_is_store;
  logic m_live;

  always_comb begin
    m_is_load  = (m_memop == MEMOP_LOAD);
    m_is_store = (m_memop == MEMOP_STORE);
    m_live     = m_valid & m_fresh;
  end

  // ---------------------------------------------------------------------------
  // Data-memory interface
  // ---------------------------------------------------------------------------
  always_comb begin
    DREQ   = m_live & (m_is_load | m_is_store);
    DRW    = m_is_store;
    DADDR  = m_alures[31:2];
    DWDATA = m_stdata;
  end

  // ---------------------------------------------------------------------------
  // Forwarding and hazard information
  // ---------------------------------------------------------------------------
  always_comb begin
    FWD_M_EN   = m_valid & m_wen & ~(m_is_load | m_is_store);
    FWD_M_RD   = m_rd;
    FWD_M_DATA = m_alures;
    LOAD_IN_M  = m_live & m_is_load;
    M_RD       = m_rd;
  end

  // ---------------------------------------------------------------------------
  // W register: captures M on every edge regardless of STALL
  // ---------------------------------------------------------------------------
  logic        w_valid;
  logic        w_isload;
  logic        w_isstore;
  logic [31:0] w_alures;
  logic [4:0]  w_rd;
  logic        w_wen;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_valid   <= 1'b0;
      w_isload  <= 1'b0;
      w_isstore <= 1'b0;
      w_alures  <= '0;
      w_rd      <= '0;
      w_wen     <= 1'b0;
    end else begin
      w_valid   <= m_live;
      w_isload  <= m_is_load;
      w_isstore <= m_is_store;
      w_alures  <= m_alures;
      w_rd      <= m_rd;
      w_wen     <= m_wen;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port; load data arrives from memory during W
  // ---------------------------------------------------------------------------
  always_comb begin
    RF_WEN = w_valid & w_wen & ~w_isstore;
    RF_WA  = w_rd;
    RF_DI  = w_isload ? DRDATA : w_alures;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: CLK  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: RSTN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: STALL  input  1  hazard-unit freeze of the M register.
REQ-004 SHALL have ports: EX_VALID  input  1  execute stage holds a live instruction.
REQ-005 SHALL have ports: EX_ALURES  input  32  ALU result / effective byte address.
REQ-006 SHALL have ports: EX_STDATA  input  32  store data.
REQ-007 SHALL have ports: EX_MEMOP  input  2  00 none, 01 load, 10 store, 11 reserved.
REQ-008 SHALL have ports: EX_RD  input  5  destination register; EX_WEN  input  1  register-write request.
REQ-009 SHALL have ports: DREQ  output  1; DRW  output  1 (1 write, 0 read); DADDR  output  30; DWDATA  output  32; DRDATA  input  32.
REQ-010 SHALL have ports: RF_WEN  output  1; RF_WA  output  5; RF_DI  output  32 (register-file write port).
REQ-011 SHALL have ports: FWD_M_EN  output  1; FWD_M_RD  output  5; FWD_M_DATA  output  32 (M-stage forward).
REQ-012 SHALL have ports: LOAD_IN_M  output  1; M_RD  output  5 (load-use hazard info).

Function
REQ-013 M register (valid, memop, alures, stdata, rd, wen, fresh) SHALL load EX_* on every rising edge with STALL=0; fresh set to 1 on load.
REQ-014 STALL=1 SHALL hold all M contents except fresh, which clears after the edge at which the entry is passed to W.
REQ-015 W register (valid, isload, alures, rd, wen) SHALL capture M on every edge; w.valid = m.valid & m.fresh, so each instruction enters W exactly once.
REQ-016 DREQ SHALL = m.valid & m.fresh & (memop 01 or 10), combinational; a stalled instruction issues memory exactly once.
REQ-017 DRW SHALL be 1 for store, 0 otherwise; DADDR = m.alures[31:2]; address bits [1:0] ignored; DWDATA = m.stdata.
REQ-018 Memory is synchronous, fixed 1-cycle read latency: DRDATA valid in the cycle after the DREQ read, i.e. while the load sits in W.
REQ-019 RF_WEN SHALL = w.valid & w.wen & not store; RF_WA = w.rd; RF_DI = DRDATA if w.isload else w.alures (combinational mux).
REQ-020 Stores SHALL never write the register file regardless of EX_WEN.
REQ-021 Memop 11 SHALL behave as 00 (no DREQ); register write governed by wen alone.
REQ-022 Register 0 is not special: rd=0 with wen=1 writes.
REQ-023 FWD_M_EN SHALL = m.valid & m.wen & memop not load/store; FWD_M_RD = m.rd; FWD_M_DATA = m.alures.
REQ-024 LOAD_IN_M SHALL = m.valid & m.fresh & memop==01; M_RD = m.rd.
REQ-025 Latency: EX->memory request 1 edge; EX->RF write presented 2 edges after capture (no stall).
REQ-026 EX_VALID=0 SHALL produce a bubble: no DREQ, no RF_WEN two cycles later.

Reset
REQ-027 RSTN low SHALL immediately clear all M and W state; DREQ, DRW, RF_WEN, FWD_M_EN, LOAD_IN_M = 0; all data outputs 0.
REQ-028 Reset during an outstanding load SHALL discard it; no RF write after RSTN rises until a new instruction flows through.
REQ-029 First edge after RSTN deassertion SHALL capture EX_* normally.

Verification
REQ-030 Load: EX_MEMOP=01, ALURES=0x0000_0104, RD=3, WEN=1 -> next cycle DREQ=1, DRW=0, DADDR=0x41; DRDATA=0xDEAD_BEEF next cycle -> RF_WEN=1, RF_WA=3, RF_DI=0xDEAD_BEEF.
REQ-031 Store: MEMOP=10, ALURES=0x200, STDATA=0x1234, WEN=1 -> DREQ=1, DRW=1, DADDR=0x80, DWDATA=0x1234; RF_WEN stays 0.
REQ-032 ALU op: MEMOP=00, ALURES=0x55, RD=7, WEN=1 -> FWD_M_EN=1, FWD_M_RD=7, FWD_M_DATA=0x55; next cycle RF write 0x55 to r7; DREQ never 1.
REQ-033 Stall: store captured, STALL=1 for 3 cycles -> DREQ high exactly 1 cycle, W valid exactly once, M contents unchanged until STALL=0.
REQ-034 Reset mid-load: assert RSTN=0 in the load's W cycle -> RF_WEN drops to 0 at once, no write after release.
REQ-035 Back-to-back load then dependent ALU op: LOAD_IN_M=1 with M_RD matching, FWD_M_EN=0 for the load.
